serial_rcv: RTL and testbench

SERIAL_RCV -- requirements
Module: serial_rcv

---
 rtl/serial_rcv_pkg.sv | 17 +
 rtl/serial_rcv_bit_timer.sv | 30 +++
 rtl/serial_rcv.sv | 153 +++++++++++++++
 tb/tb_serial_rcv.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_rcv_pkg.sv
// Shared types and constants for the serial_rcv 8N1 receiver.
package serial_rcv_pkg;

    // Number of payload bits per frame.
    localparam int DATA_BITS = 8;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ARM   = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        LOAD  = 3'd5
    } state_t;

endpackage : serial_rcv_pkg

// File: rtl/serial_rcv_bit_timer.sv
// Free-running bit timer: counts up, wraps to 0 when it reaches rollover_val,
// and flags that cycle so the FSM can take a line sample.
module bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_reg;

    // The flag is purely a compare on the stored count so that a clear
    // request derived from the flag cannot form a combinational loop.
    assign rollover_flag = (count_reg == rollover_val);

    // Count register: cleared on request, wraps on every sample strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else if (clear || rollover_flag) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule : bit_timer

// File: rtl/serial_rcv.sv
// 8N1 serial receiver: falling-edge start detection, mid-bit sampling,
// LSB-first shift register and a single-entry output buffer with
// overrun / framing status.
module serial_rcv
    import serial_rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serial_in,
    input  logic       data_read,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       overrun_error,
    output logic       framing_error
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    // START waits half a bit; DATA/STOP wait a full bit per sample.
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    state_t          state_reg, state_next;
    logic            edge_reg;
    logic [7:0]      shift_reg, shift_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      rx_data_reg, rx_data_next;
    logic            ready_reg, ready_next;
    logic            overrun_reg, overrun_next;
    logic            framing_reg, framing_next;
    logic            timer_clear;
    logic [TW-1:0]   timer_rollover;
    logic            sample_strobe;

    bit_timer #(
        .WIDTH (TW)
    ) u_bit_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (timer_clear),
        .rollover_val  (timer_rollover),
        .rollover_flag (sample_strobe)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= ARM;
            edge_reg    <= 1'b1;
            shift_reg   <= 8'h00;
            bit_idx_reg <= 3'd0;
            rx_data_reg <= 8'h00;
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            framing_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            edge_reg    <= serial_in;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            rx_data_reg <= rx_data_next;
            ready_reg   <= ready_next;
            overrun_reg <= overrun_next;
            framing_reg <= framing_next;
        end
    end

    // Next-state, sampling and output-buffer logic.
    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        bit_idx_next   = bit_idx_reg;
        rx_data_next   = rx_data_reg;
        ready_next     = ready_reg;
        overrun_next   = overrun_reg;
        framing_next   = framing_reg;
        timer_rollover = FULL_M1;

        // Consumer acknowledge; a LOAD below overrides ready in the same cycle.
        if (data_read && ready_reg) begin
            ready_next   = 1'b0;
            overrun_next = 1'b0;
        end

        case (state_reg)
            ARM: begin
                // Wait for an idle-high line before trusting edges.
                if (serial_in) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (edge_reg && !serial_in) begin
                    state_next = START;
                end
            end
            START: begin
                timer_rollover = HALF_M1;
                if (sample_strobe) begin
                    if (!serial_in) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                        framing_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample_strobe) begin
                    shift_next = {serial_in, shift_reg[7:1]};
                    if (bit_idx_reg == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (sample_strobe) begin
                    if (serial_in) begin
                        state_next = LOAD;
                    end else begin
                        framing_next = 1'b1;
                        state_next   = ARM;
                    end
                end
            end
            LOAD: begin
                rx_data_next = shift_reg;
                ready_next   = 1'b1;
                if (ready_reg && !data_read) begin
                    overrun_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = ARM;
            end
        endcase
    end

    // Every state entry restarts the bit timer.
    assign timer_clear = (state_next != state_reg);

    assign rx_data       = rx_data_reg;
    assign data_ready    = ready_reg;
    assign overrun_error = overrun_reg;
    assign framing_error = framing_reg;

endmodule : serial_rcv

// File: tb/tb_serial_rcv.sv
// Directed testbench for serial_rcv at CLKS_PER_BIT = 10.
module tb_serial_rcv;

    localparam int CPB = 10;

    logic       clk;
    logic       n_rst;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;

    int checks;
    int failures;

    serial_rcv #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    // Sends one frame. T is the rising edge that first sees the start bit;
    // optional checks/actions happen just after edges T+95 and T+96.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input bit chk_timing, input bit read_in_load);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        @(negedge clk);
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            serial_in = bits[k];
            if (k < 9) begin
                repeat (CPB) @(negedge clk);
            end else begin
                repeat (6) @(negedge clk);
                if (chk_timing) check("ready_at_T95", {7'd0, data_ready}, 8'h00);
                if (read_in_load) data_read = 1'b1;
                @(negedge clk);
                data_read = 1'b0;
                if (chk_timing) check("ready_at_T96", {7'd0, data_ready}, 8'h01);
                repeat (CPB - 7) @(negedge clk);
            end
        end
        serial_in = 1'b1;
        $display("frame %h stop=%0b sent", d, stop_bit);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        $display("data_read pulse");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        n_rst     = 1'b0;
        serial_in = 1'b0;   // synchronizer output is low in reset
        data_read = 1'b0;

        // Reset state
        #12;
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_ready", {7'd0, data_ready}, 8'h00);
        check("rst_overrun", {7'd0, overrun_error}, 8'h00);
        check("rst_framing", {7'd0, framing_error}, 8'h00);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // Good frame 0xA5 with exact ready timing
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_overrun", {7'd0, overrun_error}, 8'h00);
        check("a5_framing", {7'd0, framing_error}, 8'h00);
        pulse_read();
        check("a5_read_ready", {7'd0, data_ready}, 8'h00);

        // Short low glitch must be rejected as a false start
        @(negedge clk);
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (20) @(negedge clk);
        $display("glitch 3 cycles");
        check("glitch_ready", {7'd0, data_ready}, 8'h00);
        check("glitch_rx_data", rx_data, 8'hA5);
        check("glitch_framing", {7'd0, framing_error}, 8'h00);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check("5a_rx_data", rx_data, 8'h5A);
        check("5a_ready", {7'd0, data_ready}, 8'h01);
        pulse_read();

        // Framing error, then recovery on a good frame
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("3c_framing", {7'd0, framing_error}, 8'h01);
        check("3c_rx_data", rx_data, 8'h5A);
        check("3c_ready", {7'd0, data_ready}, 8'h00);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        check("01_framing", {7'd0, framing_error}, 8'h00);
        check("01_rx_data", rx_data, 8'h01);
        check("01_ready", {7'd0, data_ready}, 8'h01);
        pulse_read();

        // Overrun
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        check("ovr_rx_data", rx_data, 8'h22);
        check("ovr_flag", {7'd0, overrun_error}, 8'h01);
        check("ovr_ready", {7'd0, data_ready}, 8'h01);
        pulse_read();
        check("ovr_read_ready", {7'd0, data_ready}, 8'h00);
        check("ovr_read_flag", {7'd0, overrun_error}, 8'h00);

        // Read coincident with LOAD of the next byte
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0, 1'b1);
        check("coin_ready", {7'd0, data_ready}, 8'h01);
        check("coin_overrun", {7'd0, overrun_error}, 8'h00);
        check("coin_rx_data", rx_data, 8'h44);

        // Reset mid-frame, line low after release, then a good frame
        @(negedge clk);
        serial_in = 1'b0;
        repeat (55) @(negedge clk);
        n_rst = 1'b0;
        #1;
        $display("reset asserted mid-frame");
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_ready", {7'd0, data_ready}, 8'h00);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        check("armed_ready", {7'd0, data_ready}, 8'h00);
        check("armed_framing", {7'd0, framing_error}, 8'h00);
        serial_in = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check("c3_rx_data", rx_data, 8'hC3);
        check("c3_ready", {7'd0, data_ready}, 8'h01);
        check("c3_framing", {7'd0, framing_error}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_rcv
